uart_rx_deser: RTL and testbench
================================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame and width of rx_data.
REQ-002 Parameter CLK_DIV, default 4, pclk cycles per oversample tick; legal range ≥1.
REQ-003 Parameter OVERSAMPLE, default 16, ticks per bit period; even, ≥4.
REQ-004 Parameter PARITY_EN, default 0, 1 = one parity bit between data and stop.
REQ-005 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0.
REQ-006 pclk  input  1  clock.
REQ-007 prstn  input  1  reset; asynchronous, active-low.
REQ-008 rxd  input  1  asynchronous serial line; idle high.
REQ-009 rx_valid  output  1  holding register contains an unread byte.
REQ-010 rx_ready  input  1  consumer accepts the byte this cycle.
REQ-011 rx_data  output  DATA_WIDTH  received byte, LSB first on line.
REQ-012 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-013 parity_err  output  1  one-cycle pulse; parity mismatch.
REQ-014 overrun  output  1  one-cycle pulse; completed byte dropped because the holding register was full.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-016 A free-running tick counter SHALL count 0..CLK_DIV-1, wrapping to 0, and assert tick for one pclk when at CLK_DIV-1.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all state and sample-counter updates SHALL occur only on tick cycles, except reset.
REQ-018 IDLE: synchronized rxd=0 on a tick SHALL move to START with the sample counter cleared.
REQ-019 START: after OVERSAMPLE/2 ticks, sample rxd; 1 -> IDLE (glitch, no error pulse); 0 -> DATA with sample counter and bit index cleared.
REQ-020 DATA: every OVERSAMPLE ticks, sample one bit into the shift register LSB first; after DATA_WIDTH bits -> PARITY if PARITY_EN=1, else STOP.
REQ-021 PARITY: after OVERSAMPLE ticks, sample the parity bit; expected value = XOR of data bits, inverted when PARITY_ODD=1; record a mismatch.
REQ-022 STOP: after OVERSAMPLE ticks, sample rxd and return to IDLE on the same tick (mid-stop bit), so back-to-back frames are received.
REQ-023 Stop sample 0 -> frame_err pulse; byte discarded; parity_err not asserted for that frame.
REQ-024 Stop sample 1 with recorded parity mismatch -> parity_err pulse; byte discarded.
REQ-025 Stop sample 1, no mismatch -> byte delivered to the holding register exactly 1 pclk after the stop-sample tick.
REQ-026 Handshake: transfer occurs on a cycle with rx_valid=1 and rx_ready=1; rx_valid SHALL clear on the next cycle unless a new byte is delivered then.
REQ-027 While rx_valid=1 and rx_ready=0, rx_data SHALL hold stable.
REQ-028 Delivery with rx_valid=0, or with a transfer on the same cycle -> rx_data loads the new byte and rx_valid is 1 on the next cycle.
REQ-029 Delivery with rx_valid=1 and no transfer that cycle -> overrun pulse; new byte dropped; rx_data and rx_valid unchanged.
REQ-030 Error and overrun pulses SHALL be exactly one pclk wide and mutually exclusive per frame.

Reset
REQ-031 prstn low SHALL force, asynchronously: FSM IDLE; tick and sample counters 0; synchronizer flops 1; rx_valid 0; rx_data 0; frame_err, parity_err, overrun 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL resume at the next falling edge of the synchronized rxd.

Verification (CLK_DIV=4, OVERSAMPLE=16; bit period = 64 pclk)
REQ-033 8N1 frame 0xA5, rx_ready=1 -> rx_valid high 1 cycle, rx_data=0xA5, no error pulses.
REQ-034 rxd low 16 pclk, then high -> FSM returns to IDLE, rx_valid stays 0, no pulses.
REQ-035 Frame 0x3C with stop bit 0 -> frame_err single pulse, rx_valid stays 0.
REQ-036 rx_ready=0; frames 0x11 then 0x22 back-to-back -> rx_valid=1, rx_data=0x11; overrun pulse 1 cycle after second stop sample; rx_data remains 0x11.
REQ-037 PARITY_EN=1, PARITY_ODD=0; frame 0x07 with parity bit 0 -> parity_err pulse, no rx_valid; same frame with parity bit 1 -> rx_data=0x07.
REQ-038 prstn pulsed low during bit 3 of 0x5A -> all outputs 0 immediately; next frame 0xC3 received correctly.

Source files
------------

// File: rtl/uart_rx_deser.sv
// ============================================================================
// uart_rx_deser : oversampling UART receiver with optional parity and a
//                 single-entry valid/ready holding register. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  rxd,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic                  sync1, sync2, rx_s;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  state_t                state, state_n;
  logic [SW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par_bad, par_bad_n;
  logic                  stop_hit;
  logic                  deliver;
  logic                  xfer;

  // Line is idle-high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn)
      tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      par_bad <= par_bad_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    par_bad_n = par_bad;
    stop_hit  = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n     = '0;
            bit_n     = '0;
            par_bad_n = 1'b0;
            state_n   = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_n   = '0;
            shreg_n = (shreg >> 1) | (DATA_WIDTH'(rx_s) << (DATA_WIDTH - 1));
            bit_n   = bit_idx + 1'b1;
            if (bit_idx == BIT_LAST)
              state_n = HAS_PAR ? PARITY : STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt_n     = '0;
            par_bad_n = (rx_s != ((^shreg) ^ PAR_ODD));
            state_n   = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so the next start edge is not missed.
          if (cnt == FULL_LAST) begin
            cnt_n    = '0;
            stop_hit = 1'b1;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign deliver = stop_hit & rx_s & ~par_bad;
  assign xfer    = rx_valid & rx_ready;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= stop_hit & ~rx_s;
      parity_err <= stop_hit & rx_s & par_bad;
      overrun    <= deliver & rx_valid & ~rx_ready;
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (xfer) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
// Directed testbench for uart_rx_deser: one no-parity and one even-parity instance.
`default_nettype none

module tb_uart_rx_deser;

  logic       pclk = 1'b0;
  logic       prstn = 1'b0;
  logic       rxd = 1'b1, rxd_p = 1'b1;
  logic       rx_ready = 1'b1, rx_ready_p = 1'b1;
  logic       valid_a, fe_a, pe_a, ov_a;
  logic [7:0] data_a;
  logic       valid_b, fe_b, pe_b, ov_b;
  logic [7:0] data_b;

  int checks = 0;
  int errors = 0;

  uart_rx_deser #(.DATA_WIDTH(8), .CLK_DIV(4), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .pclk(pclk), .prstn(prstn), .rxd(rxd), .rx_valid(valid_a), .rx_ready(rx_ready),
    .rx_data(data_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  uart_rx_deser #(.DATA_WIDTH(8), .CLK_DIV(4), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .pclk(pclk), .prstn(prstn), .rxd(rxd_p), .rx_valid(valid_b), .rx_ready(rx_ready_p),
    .rx_data(data_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  always #5 pclk = ~pclk;

  // Cumulative cycle counts of each output being high, plus the last byte seen valid.
  int hi_a = 0, fen_a = 0, pen_a = 0, ovn_a = 0;
  int hi_b = 0, fen_b = 0, pen_b = 0, ovn_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  always @(negedge pclk) begin
    if (valid_a === 1'b1) begin hi_a++; last_a = data_a; end
    if (fe_a === 1'b1) fen_a++;
    if (pe_a === 1'b1) pen_a++;
    if (ov_a === 1'b1) ovn_a++;
    if (valid_b === 1'b1) begin hi_b++; last_b = data_b; end
    if (fe_b === 1'b1) fen_b++;
    if (pe_b === 1'b1) pen_b++;
    if (ov_b === 1'b1) ovn_b++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else     rxd   = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // stop_low > 0 holds the stop bit low for that many cycles before idling high.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input bit par_bit, input int stop_low);
    drive(sel, 1'b0);
    wait_cycles(64);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_cycles(64);
    end
    if (with_par) begin
      drive(sel, par_bit);
      wait_cycles(64);
    end
    if (stop_low > 0) begin
      drive(sel, 1'b0);
      wait_cycles(stop_low);
    end
    drive(sel, 1'b1);
    wait_cycles(64);
  endtask

  task automatic test_reset;
    prstn = 1'b0;
    wait_cycles(3);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
    checks++; if (fe_a !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", fe_a); end
    checks++; if (pe_a !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", pe_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ov_a); end
    checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_p: got %b want 0", valid_b); end
    checks++; if (data_b !== 8'h00) begin errors++; $display("FAIL reset_data_p: got %h want 00", data_b); end
    prstn = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_basic;
    int h0, f0, p0, o0;
    rx_ready = 1'b1;
    h0 = hi_a; f0 = fen_a; p0 = pen_a; o0 = ovn_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 0);
    wait_cycles(20);
    checks++; if (hi_a - h0 !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", hi_a - h0); end
    checks++; if (last_a !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", last_a); end
    checks++; if (fen_a - f0 !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d want 0", fen_a - f0); end
    checks++; if (pen_a - p0 !== 0) begin errors++; $display("FAIL basic_parity_err: got %0d want 0", pen_a - p0); end
    checks++; if (ovn_a - o0 !== 0) begin errors++; $display("FAIL basic_overrun: got %0d want 0", ovn_a - o0); end
  endtask

  task automatic test_glitch;
    int h0, f0;
    h0 = hi_a; f0 = fen_a;
    drive(1'b0, 1'b0);
    wait_cycles(16);
    drive(1'b0, 1'b1);
    wait_cycles(200);
    checks++; if (hi_a - h0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", hi_a - h0); end
    checks++; if (fen_a - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", fen_a - f0); end
    h0 = hi_a;
    send_frame(1'b0, 8'h96, 1'b0, 1'b0, 0);
    wait_cycles(20);
    checks++; if (hi_a - h0 !== 1) begin errors++; $display("FAIL glitch_recover_valid: got %0d want 1", hi_a - h0); end
    checks++; if (last_a !== 8'h96) begin errors++; $display("FAIL glitch_recover_data: got %h want 96", last_a); end
  endtask

  task automatic test_frame_err;
    int h0, f0, p0;
    h0 = hi_a; f0 = fen_a; p0 = pen_a;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 44);
    wait_cycles(100);
    checks++; if (fen_a - f0 !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles want 1", fen_a - f0); end
    checks++; if (hi_a - h0 !== 0) begin errors++; $display("FAIL frame_err_valid: got %0d want 0", hi_a - h0); end
    checks++; if (pen_a - p0 !== 0) begin errors++; $display("FAIL frame_err_parity: got %0d want 0", pen_a - p0); end
  endtask

  task automatic test_overrun;
    int f0, p0, o0;
    f0 = fen_a; p0 = pen_a; o0 = ovn_a;
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 0);
    checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL overrun_first_data: got %h want 11", data_a); end
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 0);
    wait_cycles(20);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b want 1", valid_a); end
    checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL overrun_data_held: got %h want 11", data_a); end
    checks++; if (ovn_a - o0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles want 1", ovn_a - o0); end
    checks++; if ((fen_a - f0) + (pen_a - p0) !== 0) begin errors++; $display("FAIL overrun_other_err: got %0d want 0", (fen_a - f0) + (pen_a - p0)); end
    rx_ready = 1'b1;
    wait_cycles(1);
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL handshake_clear: got %b want 0", valid_a); end
  endtask

  task automatic test_parity;
    int h0, p0, f0;
    rx_ready_p = 1'b1;
    h0 = hi_b; p0 = pen_b; f0 = fen_b;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 0);
    wait_cycles(20);
    checks++; if (pen_b - p0 !== 1) begin errors++; $display("FAIL parity_bad_pulse: got %0d cycles want 1", pen_b - p0); end
    checks++; if (hi_b - h0 !== 0) begin errors++; $display("FAIL parity_bad_valid: got %0d want 0", hi_b - h0); end
    checks++; if (fen_b - f0 !== 0) begin errors++; $display("FAIL parity_bad_frame_err: got %0d want 0", fen_b - f0); end
    h0 = hi_b; p0 = pen_b;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 0);
    wait_cycles(20);
    checks++; if (hi_b - h0 !== 1) begin errors++; $display("FAIL parity_good_valid: got %0d want 1", hi_b - h0); end
    checks++; if (last_b !== 8'h07) begin errors++; $display("FAIL parity_good_data: got %h want 07", last_b); end
    checks++; if (pen_b - p0 !== 0) begin errors++; $display("FAIL parity_good_err: got %0d want 0", pen_b - p0); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int h0, f0, p0, o0;
    d = 8'h5A;
    rx_ready = 1'b0;
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 0);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL reset_mid_pre_valid: got %b want 1", valid_a); end
    drive(1'b0, 1'b0);
    wait_cycles(64);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, d[i]);
      wait_cycles(64);
    end
    drive(1'b0, d[3]);
    wait_cycles(32);
    #1 prstn = 1'b0;
    #1;
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b want 0", valid_a); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_mid_data: got %h want 00", data_a); end
    checks++; if ({fe_a, pe_a, ov_a} !== 3'b000) begin errors++; $display("FAIL reset_mid_pulses: got %b want 000", {fe_a, pe_a, ov_a}); end
    drive(1'b0, 1'b1);
    wait_cycles(10);
    prstn = 1'b1;
    rx_ready = 1'b1;
    wait_cycles(100);
    h0 = hi_a; f0 = fen_a; p0 = pen_a; o0 = ovn_a;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 0);
    wait_cycles(20);
    checks++; if (hi_a - h0 !== 1) begin errors++; $display("FAIL reset_mid_next_valid: got %0d want 1", hi_a - h0); end
    checks++; if (last_a !== 8'hC3) begin errors++; $display("FAIL reset_mid_next_data: got %h want c3", last_a); end
    checks++; if ((fen_a - f0) + (pen_a - p0) + (ovn_a - o0) !== 0) begin
      errors++; $display("FAIL reset_mid_next_pulses: got %0d want 0", (fen_a - f0) + (pen_a - p0) + (ovn_a - o0));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_parity;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
